// File: rtl/conv_code_pkg.sv
// rtl/conv_code_pkg.sv - shared constants, types and helpers for the convolutional encoder
package conv_code_pkg;

  // Default K=5 generator taps. Tap bit 0 multiplies the current input bit.
  localparam logic [4:0] K5_G0 = 5'o23;
  localparam logic [4:0] K5_G1 = 5'o35;

  typedef enum logic {
    RUN  = 1'b0,
    TAIL = 1'b1
  } enc_state_e;

  // Callers zero-extend their tap window, so constraint lengths up to 32 are supported.
  function automatic logic parity(input logic [31:0] v);
    return ^v;
  endfunction

  // Width of a codeword-bit index. It is sized to N+1 code points so that at least
  // one out-of-range index can always be expressed (e.g. 3 for N=2). Such an index
  // must be rejected by the noise gate.
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/conv_noise_gate.sv
// rtl/conv_noise_gate.sv - density-bounded single-bit flip injector
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   load          a codeword is being loaded into the output register this cycle
//   req, sel      flip request and index of the codeword bit to flip
//   mask          one-hot flip mask for the codeword being loaded (0 = clean)
//   decosy        guard open: a flip would be honoured now
//   err_count     saturating count of honoured flips
module conv_noise_gate
  import conv_code_pkg::*;
#(
  parameter int N         = 2,
  parameter int NOISE_GAP = 8,
  parameter int CNT_W     = 16,
  parameter int SELW      = sel_width(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             req,
  input  logic [SELW-1:0]  sel,
  output logic [N-1:0]     mask,
  output logic             decosy,
  output logic [CNT_W-1:0] err_count
);

  localparam int GW = $clog2(NOISE_GAP);

  logic [GW-1:0]    guard_q, guard_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             honour;

  always_comb begin
    honour  = (guard_q == '0) && req && (32'(sel) < N);
    mask    = honour ? (N'(1) << sel) : '0;
    guard_d = guard_q;
    err_d   = err_q;
    // Guard only moves on loads, so a stalled output freezes the spacing window.
    if (load) begin
      if (honour) begin
        guard_d = GW'(NOISE_GAP - 1);
        if (err_q != '1) err_d = err_q + CNT_W'(1);
      end else if (guard_q != '0) begin
        guard_d = guard_q - GW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      guard_q <= '0;
      err_q   <= '0;
    end else begin
      guard_q <= guard_d;
      err_q   <= err_d;
    end
  end

  assign decosy    = (guard_q == '0);
  assign err_count = err_q;

endmodule

// File: rtl/conv_encoder_noisy.sv
// rtl/conv_encoder_noisy.sv - rate-1/N feed-forward convolutional encoder with noise injection
// Ports:
//   clock, reset                      rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_bit/in_last  information bit input handshake
//   noise_req, noise_sel              request a flip of codeword bit noise_sel on this load
//   out_valid/out_ready/out_code      registered codeword output handshake
//   out_last                          final codeword of a block (including the zero tail)
//   noise_applied                     flip mask applied to the held codeword
//   decosy                            guard open: a flip would be honoured now
//   err_count                         saturating count of injected flips
module conv_encoder_noisy
  import conv_code_pkg::*;
#(
  parameter int             K         = 5,
  parameter int             N         = 2,
  parameter logic [N*K-1:0] GEN       = {K5_G1, K5_G0},
  parameter int             NOISE_GAP = 8,
  parameter int             TAIL_EN   = 1,
  parameter int             CNT_W     = 16,
  localparam int            SELW      = sel_width(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  input  logic             noise_req,
  input  logic [SELW-1:0]  noise_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_code,
  output logic             out_last,
  output logic [N-1:0]     noise_applied,
  output logic             decosy,
  output logic [CNT_W-1:0] err_count
);

  localparam int TW = (K > 2) ? $clog2(K) : 1;

  enc_state_e    fsm_q, fsm_d;
  logic [K-2:0]  state_q, state_d;
  logic [TW-1:0] tail_q, tail_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_code_q, out_code_d;
  logic          out_last_q, out_last_d;
  logic [N-1:0]  noise_applied_q, noise_applied_d;

  logic          load_ok, load, b;
  logic [K-1:0]  w;
  logic [N-1:0]  code, mask;

  conv_noise_gate #(
    .N        (N),
    .NOISE_GAP(NOISE_GAP),
    .CNT_W    (CNT_W),
    .SELW     (SELW)
  ) u_gate (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .req      (noise_req),
    .sel      (noise_sel),
    .mask     (mask),
    .decosy   (decosy),
    .err_count(err_count)
  );

  always_comb begin
    load_ok  = !out_valid_q || out_ready;
    in_ready = load_ok && (fsm_q == RUN);
    // Tail beats shift in zeros without needing an input transfer.
    b        = (fsm_q == RUN) ? in_bit : 1'b0;
    load     = (fsm_q == RUN) ? (in_valid && in_ready) : load_ok;
    w        = {state_q, b};
    for (int j = 0; j < N; j++) begin
      code[j] = parity(32'(GEN[j*K +: K] & w));
    end

    fsm_d           = fsm_q;
    state_d         = state_q;
    tail_d          = tail_q;
    out_valid_d     = out_valid_q;
    out_code_d      = out_code_q;
    out_last_d      = out_last_q;
    noise_applied_d = noise_applied_q;

    if (load_ok) out_valid_d = load;

    if (load) begin
      out_code_d      = code ^ mask;
      noise_applied_d = mask;
      state_d         = w[K-2:0];
      out_last_d      = 1'b0;
      if (fsm_q == RUN) begin
        if (in_last) begin
          if (TAIL_EN != 0) begin
            fsm_d  = TAIL;
            tail_d = '0;
          end else begin
            out_last_d = 1'b1;
            state_d    = '0;
          end
        end
      end else begin
        if (tail_q == TW'(K - 2)) begin
          out_last_d = 1'b1;
          fsm_d      = RUN;
          state_d    = '0;
        end else begin
          tail_d = tail_q + TW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q           <= RUN;
      state_q         <= '0;
      tail_q          <= '0;
      out_valid_q     <= 1'b0;
      out_code_q      <= '0;
      out_last_q      <= 1'b0;
      noise_applied_q <= '0;
    end else begin
      fsm_q           <= fsm_d;
      state_q         <= state_d;
      tail_q          <= tail_d;
      out_valid_q     <= out_valid_d;
      out_code_q      <= out_code_d;
      out_last_q      <= out_last_d;
      noise_applied_q <= noise_applied_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_code      = out_code_q;
  assign out_last      = out_last_q;
  assign noise_applied = noise_applied_q;

endmodule

// File: tb/tb_conv_encoder_noisy.sv
// tb/tb_conv_encoder_noisy.sv - directed self-checking bench for conv_encoder_noisy
module tb_conv_encoder_noisy;

  localparam logic [20:0] GEN7 = {7'o171, 7'o133, 7'o165};

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_bit, in_last, noise_req;
  logic [1:0]  noise_sel;
  logic        out_valid, out_ready, out_last, decosy;
  logic [1:0]  out_code, noise_applied;
  logic [15:0] err_count;

  logic        in_valid1, in_ready1, in_bit1, in_last1, noise_req1;
  logic [1:0]  noise_sel1;
  logic        out_valid1, out_ready1, out_last1, decosy1;
  logic [2:0]  out_code1, noise_applied1;
  logic [15:0] err_count1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  conv_encoder_noisy u0 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit), .in_last(in_last),
    .noise_req(noise_req), .noise_sel(noise_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_last(out_last),
    .noise_applied(noise_applied), .decosy(decosy), .err_count(err_count)
  );

  conv_encoder_noisy #(.K(7), .N(3), .GEN(GEN7), .TAIL_EN(0)) u1 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_bit(in_bit1), .in_last(in_last1),
    .noise_req(noise_req1), .noise_sel(noise_sel1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_code(out_code1), .out_last(out_last1),
    .noise_applied(noise_applied1), .decosy(decosy1), .err_count(err_count1)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Impulse 1 with in_last, tail enabled: codes 11,01,10,10,11, last on the 5th.
  task automatic run_impulse(input string pfx);
    logic [1:0] exp_code [5];
    exp_code = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b11};
    in_valid = 1; in_bit = 1; in_last = 1; out_ready = 1; noise_req = 0;
    chk({pfx, "_ready_pre"}, 32'(in_ready), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin in_valid = 0; in_bit = 0; in_last = 0; end
      chk($sformatf("%s_code%0d", pfx, i), 32'(out_code), 32'(exp_code[i]));
      chk($sformatf("%s_valid%0d", pfx, i), 32'(out_valid), 1);
      chk($sformatf("%s_last%0d", pfx, i), 32'(out_last), (i == 4) ? 1 : 0);
      chk($sformatf("%s_ready%0d", pfx, i), 32'(in_ready), (i == 4) ? 1 : 0);
      chk($sformatf("%s_na%0d", pfx, i), 32'(noise_applied), 0);
    end
    tick();
    chk({pfx, "_drain"}, 32'(out_valid), 0);
  endtask

  logic [5:0] hist;
  logic [6:0] win;
  logic [2:0] exp3;
  logic       lst;

  initial begin
    reset = 1; in_valid = 0; in_bit = 0; in_last = 0; noise_req = 0; noise_sel = 0; out_ready = 1;
    in_valid1 = 0; in_bit1 = 0; in_last1 = 0; noise_req1 = 0; noise_sel1 = 0; out_ready1 = 1;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_code", 32'(out_code), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_na", 32'(noise_applied), 0);
    chk("rst_decosy", 32'(decosy), 1);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_ready", 32'(in_ready), 1);
    reset = 0;

    // 1. Impulse response
    run_impulse("imp1");

    // 2. Continuous noise request on all-zero input: code equals the flip mask
    in_valid = 1; in_bit = 0; in_last = 0; noise_req = 1; noise_sel = 1;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("nz_decosy%0d", i), 32'(decosy), (i % 8 == 0) ? 1 : 0);
      tick();
      chk($sformatf("nz_na%0d", i), 32'(noise_applied), (i % 8 == 0) ? 2 : 0);
      chk($sformatf("nz_code%0d", i), 32'(out_code), (i % 8 == 0) ? 2 : 0);
    end
    chk("nz_err", 32'(err_count), 3);
    noise_req = 0;
    tick(); tick(); tick();
    chk("nz_guard3", 32'(decosy), 0);
    tick();
    chk("nz_guard4", 32'(decosy), 1);
    in_valid = 0;
    tick();

    // 3. Backpressure with a flip on the first beat (bit 0 flipped: 11 -> 10)
    in_valid = 1; in_bit = 1; in_last = 1; noise_req = 1; noise_sel = 0;
    tick();
    in_valid = 0; in_bit = 0; in_last = 0; out_ready = 0;
    chk("bp_code0", 32'(out_code), 2);
    chk("bp_na0", 32'(noise_applied), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_hold_code%0d", i), 32'(out_code), 2);
      chk($sformatf("bp_hold_na%0d", i), 32'(noise_applied), 1);
      chk($sformatf("bp_hold_last%0d", i), 32'(out_last), 0);
      chk($sformatf("bp_hold_ready%0d", i), 32'(in_ready), 0);
      chk($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 1);
    end
    out_ready = 1;
    tick(); chk("bp_code1", 32'(out_code), 1);
    tick(); chk("bp_code2", 32'(out_code), 2);
    tick(); chk("bp_code3", 32'(out_code), 2);
    chk("bp_na3", 32'(noise_applied), 0);
    tick(); chk("bp_code4", 32'(out_code), 3);
    chk("bp_last4", 32'(out_last), 1);
    out_ready = 0;
    tick(); tick();
    chk("bp_lasthold_last", 32'(out_last), 1);
    chk("bp_lasthold_code", 32'(out_code), 3);
    chk("bp_lasthold_ready", 32'(in_ready), 0);
    out_ready = 1;
    tick();
    chk("bp_drain", 32'(out_valid), 0);
    chk("bp_err", 32'(err_count), 4);
    // Guard went 7 -> 3 over the four tail loads; three more loads open it.
    noise_req = 0; in_valid = 1; in_bit = 0;
    tick(); tick();
    chk("bp_guard_frozen", 32'(decosy), 0);
    tick();
    chk("bp_guard_open", 32'(decosy), 1);
    in_valid = 0;
    tick();

    // 4. Out-of-range noise_sel is ignored
    in_valid = 1; in_bit = 0; noise_req = 1; noise_sel = 3;
    tick();
    chk("sel3_code", 32'(out_code), 0);
    chk("sel3_na", 32'(noise_applied), 0);
    chk("sel3_err", 32'(err_count), 4);
    chk("sel3_decosy", 32'(decosy), 1);
    noise_sel = 2;
    tick();
    chk("sel2_na", 32'(noise_applied), 0);
    chk("sel2_err", 32'(err_count), 4);
    in_valid = 0; noise_req = 0;
    tick();

    // 5. Reset during tail beat 2
    in_valid = 1; in_bit = 1; in_last = 1; noise_req = 1; noise_sel = 1;
    tick();
    in_valid = 0; in_bit = 0; in_last = 0;
    chk("rt_code0", 32'(out_code), 1);
    chk("rt_err", 32'(err_count), 5);
    tick();
    reset = 1;
    tick();
    chk("rt_valid", 32'(out_valid), 0);
    chk("rt_decosy", 32'(decosy), 1);
    chk("rt_err0", 32'(err_count), 0);
    chk("rt_last", 32'(out_last), 0);
    chk("rt_ready", 32'(in_ready), 1);
    reset = 0; noise_req = 0;
    run_impulse("imp2");

    // 6. K=7, N=3, no tail, random bits against a reference model
    hist = '0;
    for (int i = 0; i < 24; i++) begin
      in_bit1   = 1'($urandom_range(0, 1));
      lst       = (i == 11) || (i == 23);
      in_last1  = lst;
      in_valid1 = 1;
      win  = {hist, in_bit1};
      exp3 = '0;
      for (int j = 0; j < 3; j++)
        for (int t = 0; t < 7; t++)
          if (GEN7[j*7 + t] && win[t]) exp3[j] = ~exp3[j];
      hist = lst ? 6'd0 : {hist[4:0], in_bit1};
      chk($sformatf("k7_ready%0d", i), 32'(in_ready1), 1);
      tick();
      chk($sformatf("k7_code%0d", i), 32'(out_code1), 32'(exp3));
      chk($sformatf("k7_last%0d", i), 32'(out_last1), 32'(lst));
      chk($sformatf("k7_valid%0d", i), 32'(out_valid1), 1);
    end
    in_valid1 = 0;
    tick();
    chk("k7_drain", 32'(out_valid1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
